mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_if.sv | 55 +++++
 rtl/mem_arbiter.sv | 170 +++++++++++++++++
 tb/tb_mem_arbiter.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Bus bundle shared by the fetch/load/store requesters, the arbiter and the
// downstream memory controller. The arbiter takes the slave view; the
// requesters and memory side together take the master view.
interface mem_arbiter_if;
    // fetch requester
    logic        if_req;
    logic [31:0] if_addr;
    logic        flush;
    logic [31:0] if_data;
    logic [31:0] if_pc;
    logic        if_done;
    // load requester
    logic        ld_req;
    logic [31:0] ld_addr;
    logic [31:0] ld_data;
    logic        ld_done;
    // store requester
    logic        st_req;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic [1:0]  st_len;
    logic        st_done;
    // downstream instruction port
    logic        mc_inst_req;
    logic [31:0] mc_inst_addr;
    logic [31:0] mc_inst;
    logic [31:0] mc_inst_pc;
    logic        mc_inst_done;
    // downstream data port
    logic        mc_r_req;
    logic        mc_w_req;
    logic [31:0] mc_addr;
    logic [3:0]  mc_wptr;
    logic [31:0] mc_wdata;
    logic [31:0] mc_r_data;
    logic        mc_done;

    modport slave (
        input  if_req, if_addr, flush, ld_req, ld_addr,
               st_req, st_addr, st_data, st_len,
               mc_inst, mc_inst_pc, mc_inst_done, mc_r_data, mc_done,
        output if_data, if_pc, if_done, ld_data, ld_done, st_done,
               mc_inst_req, mc_inst_addr, mc_r_req, mc_w_req,
               mc_addr, mc_wptr, mc_wdata
    );

    modport master (
        output if_req, if_addr, flush, ld_req, ld_addr,
               st_req, st_addr, st_data, st_len,
               mc_inst, mc_inst_pc, mc_inst_done, mc_r_data, mc_done,
        input  if_data, if_pc, if_done, ld_data, ld_done, st_done,
               mc_inst_req, mc_inst_addr, mc_r_req, mc_w_req,
               mc_addr, mc_wptr, mc_wdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter: serialises instruction fetch, load and store
// requests onto one downstream controller. Stores beat loads beat fetches,
// except that a fetch kept waiting through STARVE_LIMIT data grants wins.
// One transaction is in flight at a time and every transaction is followed
// by an IDLE turnaround cycle in which the next grant is decided.
module mem_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic         clk,
    input  logic         rst,
    mem_arbiter_if.slave bus
);
    localparam int DATA_W = 32;
    localparam logic [2:0] LIMIT = 3'(STARVE_LIMIT);

    typedef enum logic [1:0] {IDLE, FETCH, LOAD, STORE} state_t;

    state_t            state;
    state_t            state_nxt;
    logic              grant_fetch;
    logic              grant_load;
    logic              grant_store;
    logic              fetch_ok;
    logic              drop_fetch;
    logic [2:0]        starve_cnt;
    logic              discard;
    logic [DATA_W-1:0] inst_addr_p1;
    logic [DATA_W-1:0] data_addr_p1;
    logic [DATA_W-1:0] wdata_p1;
    logic [3:0]        wptr_p1;

    // Starvation counter increment, saturating at the limit.
    function automatic logic [2:0] sat_inc(input logic [2:0] v);
        return (v >= LIMIT) ? LIMIT : v + 3'd1;
    endfunction

    // Byte lane where the right-aligned store data starts; length code 2 is
    // not a legal size and is widened to a full word.
    function automatic logic [3:0] wptr_of(input logic [1:0] len);
        case (len)
            2'd0:    return 4'h3;
            2'd1:    return 4'h2;
            default: return 4'h0;
        endcase
    endfunction

    // A flush in IDLE suppresses the fetch grant for that cycle.
    assign fetch_ok = bus.if_req & ~bus.flush;

    // A fetch completing while flushed or abandoned is swallowed.
    assign drop_fetch = discard | bus.flush | ~bus.if_req;

    // Downstream requests fall in the done cycle so the controller never
    // sees a restart on the same edge it finishes.
    assign bus.mc_inst_req  = (state == FETCH) & ~bus.mc_inst_done;
    assign bus.mc_r_req     = (state == LOAD)  & ~bus.mc_done;
    assign bus.mc_w_req     = (state == STORE) & ~bus.mc_done;
    assign bus.mc_inst_addr = inst_addr_p1;
    assign bus.mc_addr      = data_addr_p1;
    assign bus.mc_wdata     = wdata_p1;
    assign bus.mc_wptr      = wptr_p1;

    // Arbitration in IDLE and completion detection in the busy states.
    always_comb begin
        state_nxt   = state;
        grant_fetch = 1'b0;
        grant_load  = 1'b0;
        grant_store = 1'b0;
        case (state)
            IDLE: begin
                if (fetch_ok && (starve_cnt == LIMIT)) begin
                    grant_fetch = 1'b1;
                    state_nxt   = FETCH;
                end else if (bus.st_req) begin
                    grant_store = 1'b1;
                    state_nxt   = STORE;
                end else if (bus.ld_req) begin
                    grant_load = 1'b1;
                    state_nxt  = LOAD;
                end else if (fetch_ok) begin
                    grant_fetch = 1'b1;
                    state_nxt   = FETCH;
                end
            end
            FETCH: begin
                if (bus.mc_inst_done) state_nxt = IDLE;
            end
            LOAD, STORE: begin
                if (bus.mc_done) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Count data grants that overtake a waiting fetch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt <= 3'd0;
        end else if (state == IDLE) begin
            if (grant_fetch || !bus.if_req)      starve_cnt <= 3'd0;
            else if (grant_load || grant_store)  starve_cnt <= sat_inc(starve_cnt);
        end
    end

    // Remember a flush or abandoned fetch until the controller finishes it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                     discard <= 1'b0;
        else if (state != FETCH || bus.mc_inst_done) discard <= 1'b0;
        else if (bus.flush || !bus.if_req)           discard <= 1'b1;
    end

    // Capture the granted request so requester changes cannot disturb it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inst_addr_p1 <= '0;
            data_addr_p1 <= '0;
            wdata_p1     <= '0;
            wptr_p1      <= 4'h0;
        end else begin
            if (grant_fetch) inst_addr_p1 <= bus.if_addr;
            if (grant_load)  data_addr_p1 <= bus.ld_addr;
            if (grant_store) begin
                data_addr_p1 <= bus.st_addr;
                wdata_p1     <= bus.st_data;
                wptr_p1      <= wptr_of(bus.st_len);
            end
        end
    end

    // Return results and one-cycle done pulses to the requesters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.if_data <= '0;
            bus.if_pc   <= '0;
            bus.if_done <= 1'b0;
            bus.ld_data <= '0;
            bus.ld_done <= 1'b0;
            bus.st_done <= 1'b0;
        end else begin
            bus.if_done <= 1'b0;
            bus.ld_done <= 1'b0;
            bus.st_done <= 1'b0;
            case (state)
                FETCH: begin
                    if (bus.mc_inst_done && !drop_fetch) begin
                        bus.if_data <= bus.mc_inst;
                        bus.if_pc   <= bus.mc_inst_pc;
                        bus.if_done <= 1'b1;
                    end
                end
                LOAD: begin
                    if (bus.mc_done) begin
                        bus.ld_data <= bus.mc_r_data;
                        bus.ld_done <= 1'b1;
                    end
                end
                STORE: begin
                    if (bus.mc_done) bus.st_done <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed and randomized bench for mem_arbiter. The bench plays the three
// requesters and the downstream controller, predicting grant order from the
// priority rules and results from the data it hands back.
module tb_mem_arbiter;
    localparam int LIMIT   = 4;
    localparam int K_NONE  = 0;
    localparam int K_FETCH = 1;
    localparam int K_LOAD  = 2;
    localparam int K_STORE = 3;

    logic clk;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    mem_arbiter_if bus ();

    mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] active_kind();
        logic [31:0] k;
        k = K_NONE;
        if (bus.mc_inst_req) k = K_FETCH;
        if (bus.mc_r_req)    k = K_LOAD;
        if (bus.mc_w_req)    k = K_STORE;
        return k;
    endfunction

    function automatic logic [31:0] req_count();
        return 32'(bus.mc_inst_req) + 32'(bus.mc_r_req) + 32'(bus.mc_w_req);
    endfunction

    function automatic logic [31:0] dones();
        return {29'd0, bus.if_done, bus.ld_done, bus.st_done};
    endfunction

    function automatic logic [31:0] exp_wptr(input logic [1:0] len);
        case (len)
            2'd0:    return 32'h3;
            2'd1:    return 32'h2;
            default: return 32'h0;
        endcase
    endfunction

    task automatic drop_req(input int kind);
        if (kind == K_FETCH) bus.if_req = 1'b0;
        if (kind == K_LOAD)  bus.ld_req = 1'b0;
        if (kind == K_STORE) bus.st_req = 1'b0;
    endtask

    // Wait (bounded) for the next downstream request and check what it is.
    task automatic expect_grant(input string tag, input int kind, input logic [31:0] addr,
                                input int want_wait);
        int waited;
        bit seen;
        waited = 0;
        seen   = 1'b0;
        while (!seen && waited < 20) begin
            tick();
            waited++;
            if (waited == 1) check($sformatf("%s done-cleared", tag), dones(), 0);
            if (req_count() != 0) seen = 1'b1;
        end
        check($sformatf("%s wait", tag), 32'(waited), 32'(want_wait));
        check($sformatf("%s kind", tag), active_kind(), 32'(kind));
        check($sformatf("%s onehot", tag), req_count(), 1);
        check($sformatf("%s addr", tag),
              (kind == K_FETCH) ? bus.mc_inst_addr : bus.mc_addr, addr);
    endtask

    // Let the controller run lat cycles, answer with done, check the result.
    task automatic finish_txn(input string tag, input int kind, input int lat,
                              input logic [31:0] rdata, input logic [31:0] pc,
                              input logic [31:0] addr, input bit want_done, input bit keep);
        logic [31:0] pat;
        for (int i = 1; i < lat; i++) tick();
        check($sformatf("%s busy-kind", tag), active_kind(), 32'(kind));
        check($sformatf("%s busy-addr", tag),
              (kind == K_FETCH) ? bus.mc_inst_addr : bus.mc_addr, addr);
        if (kind == K_FETCH) begin
            bus.mc_inst      = rdata;
            bus.mc_inst_pc   = pc;
            bus.mc_inst_done = 1'b1;
        end else begin
            bus.mc_r_data = rdata;
            bus.mc_done   = 1'b1;
        end
        #1;
        check($sformatf("%s req-in-done-cycle", tag), req_count(), 0);
        tick();
        bus.mc_inst_done = 1'b0;
        bus.mc_done      = 1'b0;
        bus.mc_r_data    = $urandom;
        bus.mc_inst      = $urandom;
        bus.mc_inst_pc   = $urandom;
        pat = 0;
        if (want_done) pat = (kind == K_FETCH) ? 32'd4 : (kind == K_LOAD) ? 32'd2 : 32'd1;
        check($sformatf("%s done-pulse", tag), dones(), pat);
        if (want_done && kind == K_LOAD) check($sformatf("%s ld_data", tag), bus.ld_data, rdata);
        if (want_done && kind == K_FETCH) begin
            check($sformatf("%s if_data", tag), bus.if_data, rdata);
            check($sformatf("%s if_pc", tag), bus.if_pc, pc);
        end
        check($sformatf("%s idle-after", tag), req_count(), 0);
        if (!keep) drop_req(kind);
    endtask

    task automatic check_all_zero(input string tag);
        check($sformatf("%s reqs", tag), req_count(), 0);
        check($sformatf("%s dones", tag), dones(), 0);
        check($sformatf("%s ld_data", tag), bus.ld_data, 0);
        check($sformatf("%s if_data", tag), bus.if_data, 0);
        check($sformatf("%s if_pc", tag), bus.if_pc, 0);
        check($sformatf("%s mc_addr", tag), bus.mc_addr, 0);
        check($sformatf("%s mc_inst_addr", tag), bus.mc_inst_addr, 0);
        check($sformatf("%s mc_wdata", tag), bus.mc_wdata, 0);
        check($sformatf("%s mc_wptr", tag), 32'(bus.mc_wptr), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [2:0]  mask;
        logic [31:0] fa, la, sa, sd, rd, ea;
        logic [1:0]  sl;
        int          q[$];
        int          k;

        rst = 1'b1;
        bus.if_req = 0; bus.if_addr = 0; bus.flush = 0;
        bus.ld_req = 0; bus.ld_addr = 0;
        bus.st_req = 0; bus.st_addr = 0; bus.st_data = 0; bus.st_len = 0;
        bus.mc_inst = 0; bus.mc_inst_pc = 0; bus.mc_inst_done = 0;
        bus.mc_r_data = 0; bus.mc_done = 0;
        repeat (2) tick();
        check_all_zero("reset");
        rst = 1'b0;

        // Single load, controller answers on the 6th request cycle.
        bus.ld_addr = 32'h100;
        bus.ld_req  = 1'b1;
        expect_grant("load", K_LOAD, 32'h100, 1);
        bus.ld_addr = 32'h5555_0000;
        finish_txn("load", K_LOAD, 6, 32'hDEADBEEF, 0, 32'h100, 1, 0);

        // Half-word store; requester inputs scrambled after the grant.
        bus.st_addr = 32'h30; bus.st_data = 32'h0000ABCD; bus.st_len = 2'd1;
        bus.st_req  = 1'b1;
        expect_grant("store", K_STORE, 32'h30, 1);
        check("store wptr", 32'(bus.mc_wptr), 32'h2);
        check("store wdata", bus.mc_wdata, 32'h0000ABCD);
        bus.st_data = 32'hFFFF_1234; bus.st_len = 2'd3; bus.st_addr = 32'h99;
        finish_txn("store", K_STORE, 3, 0, 0, 32'h30, 1, 0);
        check("store wptr-held", 32'(bus.mc_wptr), 32'h2);
        check("store wdata-held", bus.mc_wdata, 32'h0000ABCD);

        // All three at once: store, load, fetch with one IDLE between each.
        bus.if_addr = 32'h80; bus.ld_addr = 32'h48;
        bus.st_addr = 32'h44; bus.st_data = 32'h5A; bus.st_len = 2'd0;
        bus.if_req = 1; bus.ld_req = 1; bus.st_req = 1;
        expect_grant("order1", K_STORE, 32'h44, 1);
        check("order1 wptr", 32'(bus.mc_wptr), 32'h3);
        finish_txn("order1", K_STORE, 2, 0, 0, 32'h44, 1, 0);
        expect_grant("order2", K_LOAD, 32'h48, 1);
        finish_txn("order2", K_LOAD, 2, 32'h1111_2222, 0, 32'h48, 1, 0);
        expect_grant("order3", K_FETCH, 32'h80, 1);
        finish_txn("order3", K_FETCH, 3, 32'h0000_0013, 32'h80, 32'h80, 1, 0);

        // Fetch held while loads stream: fetch wins after LIMIT loads.
        bus.if_addr = 32'hC0; bus.if_req = 1;
        bus.ld_addr = 32'h200; bus.ld_req = 1;
        for (int i = 0; i < LIMIT; i++) begin
            ea = 32'h200 + 32'(4 * i);
            expect_grant($sformatf("starve-ld%0d", i), K_LOAD, ea, 1);
            finish_txn($sformatf("starve-ld%0d", i), K_LOAD, 2, 32'hA000 + 32'(i), 0, ea, 1, 1);
            bus.ld_addr = ea + 32'd4;
        end
        expect_grant("starve-fetch", K_FETCH, 32'hC0, 1);
        finish_txn("starve-fetch", K_FETCH, 2, 32'h0BAD_F00D, 32'hC0, 32'hC0, 1, 0);
        ea = 32'h200 + 32'(4 * LIMIT);
        expect_grant("starve-ld-last", K_LOAD, ea, 1);
        finish_txn("starve-ld-last", K_LOAD, 1, 32'h7777_0001, 0, ea, 1, 0);

        // Flush in IDLE holds off the fetch grant for that cycle.
        bus.if_addr = 32'h10; bus.if_req = 1; bus.flush = 1;
        tick();
        check("flush-idle no-grant", req_count(), 0);
        bus.flush = 0;
        expect_grant("flush-idle", K_FETCH, 32'h10, 1);
        finish_txn("flush-idle", K_FETCH, 1, 32'h0000_0093, 32'h10, 32'h10, 1, 0);

        // Flush two cycles into a fetch: no if_done, refetch at new address.
        bus.if_addr = 32'h20; bus.if_req = 1;
        expect_grant("flush-fetch", K_FETCH, 32'h20, 1);
        tick();
        tick();
        bus.flush = 1; bus.if_addr = 32'h24;
        tick();
        bus.flush = 0;
        finish_txn("flush-fetch", K_FETCH, 2, 32'hBBBB_BBBB, 32'h20, 32'h20, 0, 1);
        expect_grant("refetch", K_FETCH, 32'h24, 1);
        finish_txn("refetch", K_FETCH, 2, 32'hCCCC_0001, 32'h24, 32'h24, 1, 0);

        // Fetch abandoned by its requester completes silently.
        bus.if_addr = 32'h60; bus.if_req = 1;
        expect_grant("abandon", K_FETCH, 32'h60, 1);
        bus.if_req = 0;
        finish_txn("abandon", K_FETCH, 3, 32'hEEEE_EEEE, 32'h60, 32'h60, 0, 0);

        // Reset in the middle of a load.
        bus.ld_addr = 32'h300; bus.ld_req = 1;
        expect_grant("rst-load", K_LOAD, 32'h300, 1);
        tick();
        #2;
        rst = 1'b1;
        #1;
        check_all_zero("rst-mid");
        bus.mc_done = 1'b1;
        tick();
        tick();
        check("rst-mid no ld_done", dones(), 0);
        bus.mc_done = 1'b0;
        rst = 1'b0;
        expect_grant("after-rst", K_LOAD, 32'h300, 1);
        finish_txn("after-rst", K_LOAD, 2, 32'h3030_3030, 0, 32'h300, 1, 0);

        // Random mixes of requesters; order follows store > load > fetch.
        for (int it = 0; it < 30; it++) begin
            mask = 3'($urandom_range(1, 7));
            fa = $urandom; la = $urandom; sa = $urandom; sd = $urandom;
            sl = 2'($urandom);
            bus.if_addr = fa; bus.ld_addr = la;
            bus.st_addr = sa; bus.st_data = sd; bus.st_len = sl;
            bus.if_req = mask[0]; bus.ld_req = mask[1]; bus.st_req = mask[2];
            q.delete();
            if (mask[2]) q.push_back(K_STORE);
            if (mask[1]) q.push_back(K_LOAD);
            if (mask[0]) q.push_back(K_FETCH);
            foreach (q[j]) begin
                k  = q[j];
                ea = (k == K_FETCH) ? fa : (k == K_LOAD) ? la : sa;
                rd = $urandom;
                expect_grant($sformatf("rnd%0d.%0d", it, j), k, ea, 1);
                if (k == K_LOAD) begin
                    bus.ld_addr = $urandom;
                    if ($urandom_range(0, 1) == 1) bus.ld_req = 1'b0;
                end
                if (k == K_STORE) begin
                    bus.st_addr = $urandom; bus.st_data = $urandom; bus.st_len = 2'($urandom);
                    if ($urandom_range(0, 1) == 1) bus.st_req = 1'b0;
                end
                finish_txn($sformatf("rnd%0d.%0d", it, j), k, int'($urandom_range(1, 5)),
                           rd, fa, ea, 1, 0);
                if (k == K_STORE) begin
                    check($sformatf("rnd%0d wptr", it), 32'(bus.mc_wptr), exp_wptr(sl));
                    check($sformatf("rnd%0d wdata", it), bus.mc_wdata, sd);
                end
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
